mem_1rw_byte_mask_req_buffer: RTL
=================================

// Module: mem_1rw_byte_mask_req_buffer
// PURPOSE
//  Valid/ready request front-end for the single-port byte-masked SRAM wrappers
//  (hard_mem_1rw_byte_mask_d*_w*_wrapper). Accepts read/write requests and drives
//  the wrapper's v_i/w_i/addr_i/data_i/write_mask_i ports. Captures the
//  1-cycle-latency read data into a 2-entry buffer so downstream backpressure
//  never loses data. Sustains one request per cycle when the consumer always accepts.
// PARAMETERS
//  width_p        64              data width; multiple of 8
//  els_p          512             SRAM depth
//  addr_width_lp  $clog2(els_p)   derived; address width
//  mask_width_lp  width_p>>3      derived; byte-mask width, 1 bit per byte
// PORTS
//  clk_i             in   1              clock; single clock domain
//  reset_n_i         in   1              asynchronous, active-low reset
//  v_i               in   1              request valid
//  ready_o           out  1              request ready; accept = v_i & ready_o
//  w_i               in   1              1 = write, 0 = read
//  addr_i            in   addr_width_lp  request address
//  data_i            in   width_p        write data
//  write_mask_i      in   mask_width_lp  byte write enables; 1 = write that byte
//  v_o               out  1              read data valid
//  data_o            out  width_p        read data
//  yumi_i            in   1              consumer takes data_o; legal only when v_o=1
//  mem_v_o           out  1              to wrapper v_i
//  mem_w_o           out  1              to wrapper w_i
//  mem_addr_o        out  addr_width_lp  to wrapper addr_i
//  mem_data_o        out  width_p        to wrapper data_i
//  mem_write_mask_o  out  mask_width_lp  to wrapper write_mask_i
//  mem_data_i        in   width_p        from wrapper data_o; valid the cycle after a read
// BEHAVIOUR
//  - All flops are reset asynchronously by reset_n_i=0.
//  - While reset_n_i=0: ready_o=0, v_o=0, mem_v_o=0, pend_r=0, buffer count=0.
//  - State:
//      pend_r     = 1 when a read issued last cycle; its data is on mem_data_i now.
//      2-entry FIFO, fcnt in 0..2, with rd/wr pointers that wrap mod 2.
//  - Credit rule: ready_o = (fcnt + pend_r) < 2.
//      ready_o depends only on registered state; no combinational path from
//      v_i or yumi_i.
//  - Issue: mem_v_o = v_i & ready_o. mem_w_o, mem_addr_o, mem_data_o and
//    mem_write_mask_o pass through from the request in the same cycle.
//  - Writes consume no credit and produce no response.
//    They are still stalled whenever ready_o=0.
//  - pend_r next = accepted & ~w_i.
//  - Read data path, cycle N+1 after a read accepted in cycle N:
//      fcnt=0: bypass. v_o=1 and data_o=mem_data_i.
//        If yumi_i=1, nothing is written to the FIFO.
//        Otherwise mem_data_i is written to the FIFO.
//      fcnt>0: v_o=1 and data_o=FIFO head. mem_data_i is always written to the
//        FIFO; the credit rule guarantees it has room.
//  - v_o = (fcnt>0) | pend_r.
//  - yumi_i pops the FIFO head when fcnt>0; otherwise it consumes the bypass data.
//  - Simultaneous push and pop: fcnt unchanged, both pointers advance.
//  - yumi_i while v_o=0 is illegal; the block asserts on it in simulation.
//  - Read latency: v_o rises in cycle N+1. Data order equals read acceptance order.
//  - Write then read to the same address on consecutive cycles returns the new
//    data. This is SRAM semantics; the block does not forward data.
//  - Reset mid-operation: pending and buffered reads are discarded. No response
//    is produced for them after reset deasserts.
//  - After reset deasserts, ready_o=1 on the first clock edge.
// TESTING
//  1. Reset, then write addr 5 = 0x0123_4567_89AB_CDEF with mask 0xFF, then read
//     addr 5 -> v_o=1 the cycle after the read; data_o=0x0123_4567_89AB_CDEF.
//  2. Write 0xFFFF...FF to addr 7, then write 0 to addr 7 with mask 0x0F, then read
//     -> data_o=0xFFFF_FFFF_0000_0000.
//  3. yumi_i held 1; back-to-back reads of addr 0..15 -> ready_o stays 1;
//     16 responses on consecutive cycles, in order.
//  4. yumi_i held 0; issue 3 reads -> ready_o drops after the 2nd; fcnt=2.
//     Release yumi_i -> both responses in order, then the 3rd is accepted.
//  5. Read accepted, then reset_n_i pulsed low the next cycle -> v_o=0 immediately;
//     no response after reset; ready_o=1 after release.
//  6. Random v_i/w_i/yumi_i/mask for 10k cycles against a reference memory model
//     -> every response matches; no loss or duplication; no illegal-yumi assertion.

Source files
------------

// File: rtl/mem_1rw_byte_mask_req_buffer.sv
// Valid/ready request front-end for a 1-cycle-latency byte-masked single-port SRAM.
// Read data is bypassed or parked in a 2-entry buffer so consumer backpressure never drops it.

module mem_1rw_byte_mask_req_buffer_chk (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic i_yumi,
    input  logic i_v
);

    // A consumer may only take data that is actually being offered
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (i_v | ~i_yumi);
        end
    end

endmodule

module mem_1rw_byte_mask_req_buffer #(
    parameter int width_p = 64,
    parameter int els_p   = 512,
    localparam int addr_width_lp = $clog2(els_p),
    localparam int mask_width_lp = width_p >> 3
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     v_i,
    output logic                     ready_o,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [mask_width_lp-1:0] write_mask_i,
    output logic                     v_o,
    output logic [width_p-1:0]       data_o,
    input  logic                     yumi_i,
    output logic                     mem_v_o,
    output logic                     mem_w_o,
    output logic [addr_width_lp-1:0] mem_addr_o,
    output logic [width_p-1:0]       mem_data_o,
    output logic [mask_width_lp-1:0] mem_write_mask_o,
    input  logic [width_p-1:0]       mem_data_i
);

    logic                r_live;
    logic                r_pend;
    logic [1:0]          r_fcnt;
    logic                r_wptr;
    logic                r_rptr;
    logic [width_p-1:0]  r_fifo [2];

    logic                w_fifo_nempty;
    logic                w_credit;
    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic [1:0]          w_fcnt_nxt;

    // Credit, handshake and buffer occupancy; r_live holds ready low through reset
    always_comb begin
        w_fifo_nempty = (r_fcnt != 2'd0);
        w_credit      = (({1'b0, r_fcnt} + {2'b00, r_pend}) < 3'd2);
        w_accept      = v_i & r_live & w_credit;
        w_push        = r_pend & (w_fifo_nempty | ~yumi_i);
        w_pop         = yumi_i & w_fifo_nempty;
        w_fcnt_nxt    = r_fcnt;
        if (w_push & ~w_pop) begin
            w_fcnt_nxt = r_fcnt + 2'd1;
        end else if (w_pop & ~w_push) begin
            w_fcnt_nxt = r_fcnt - 2'd1;
        end else begin
            w_fcnt_nxt = r_fcnt;
        end
    end

    assign ready_o          = r_live & w_credit;
    assign mem_v_o          = w_accept;
    assign mem_w_o          = w_i;
    assign mem_addr_o       = addr_i;
    assign mem_data_o       = data_i;
    assign mem_write_mask_o = write_mask_i;
    assign v_o              = w_fifo_nempty | r_pend;
    assign data_o           = w_fifo_nempty ? r_fifo[r_rptr] : mem_data_i;

    // Control state: read-in-flight flag, occupancy and pointers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_live <= 1'b0;
            r_pend <= 1'b0;
            r_fcnt <= 2'd0;
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
        end else begin
            r_live <= 1'b1;
            r_pend <= w_accept & ~w_i;
            r_fcnt <= w_fcnt_nxt;
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
        end
    end

    // Read-data storage, written whenever returning data is not taken on bypass
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_fifo[0] <= {width_p{1'b0}};
            r_fifo[1] <= {width_p{1'b0}};
        end else if (w_push) begin
            r_fifo[r_wptr] <= mem_data_i;
        end
    end

    mem_1rw_byte_mask_req_buffer_chk u_chk (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .i_yumi    (yumi_i),
        .i_v       (v_o)
    );

endmodule
